// File: rtl/regfile_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard_pkg
//  Purpose  : Shared core constants for the register file / scoreboard slice.
//             Defaults for data width, register count and address width.
//  Revision : 1.0  initial release
// ============================================================================
package regfile_scoreboard_pkg;

  localparam int CORE_XLEN  = 32;
  localparam int CORE_NREGS = 32;
  localparam int CORE_AW    = $clog2(CORE_NREGS);

endpackage : regfile_scoreboard_pkg
`default_nettype wire

// File: rtl/busy_table.sv
`default_nettype none
// ============================================================================
//  Module   : busy_table
//  Purpose  : Per-register pending-write (busy) bits, issue/writeback update,
//             registered popcount of busy bits and sticky writeback error.
//  Ports    : clk, reset_n          clock, async active-low reset
//             iss_valid/iss_rd      reserve destination register
//             wb_valid/wb_rd        writeback, clears reservation
//             busy                  current busy vector (bit 0 always 0)
//             busy_count            number of reserved registers
//             wb_err                sticky: writeback to unreserved register
//  Revision : 1.0  initial release
// ============================================================================
module busy_table
  import regfile_scoreboard_pkg::*;
#(
  parameter int NREGS = CORE_NREGS,
  parameter int AW    = CORE_AW,
  parameter int CW    = $clog2(NREGS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  output logic [NREGS-1:0] busy,
  output logic [CW-1:0]    busy_count,
  output logic             wb_err
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_wb_err;
  logic             w_wb_act;
  logic             w_iss_act;

  assign w_wb_act  = wb_valid  && (wb_rd  != '0);
  assign w_iss_act = iss_valid && (iss_rd != '0);

  // Writeback clears first, then issue sets: a same-edge collision leaves
  // the register reserved for the younger instruction.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wb_act)  w_busy_nxt[wb_rd]  = 1'b0;
    if (w_iss_act) w_busy_nxt[iss_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Count is taken from the next-state vector so the register matches the
  // busy bits it is stored alongside.
  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_count_nxt = w_count_nxt + CW'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy   <= '0;
      r_count  <= '0;
      r_wb_err <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_count <= w_count_nxt;
      if (w_wb_act && !r_busy[wb_rd]) r_wb_err <= 1'b1;
    end
  end

  assign busy       = r_busy;
  assign busy_count = r_count;
  assign wb_err     = r_wb_err;

endmodule : busy_table
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Purpose  : Multi-port register file with writeback bypass and a busy-bit
//             scoreboard. Register 0 is hardwired to zero.
//  Ports    : clk, reset_n          clock, async active-low reset
//             rs_addr/rs_data       NREAD packed read ports (comb. read)
//             rs_busy               per-port pending-write flag
//             iss_valid/iss_rd      reserve destination register
//             wb_valid/wb_rd/wb_data writeback
//             busy_count            number of reserved registers
//             wb_err                sticky writeback-to-unreserved flag
//  Revision : 1.0  initial release
// ============================================================================
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN  = CORE_XLEN,
  parameter int NREGS = CORE_NREGS,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS),
  localparam int CW   = $clog2(NREGS + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  output logic [NREAD-1:0]      rs_busy,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic [CW-1:0]         busy_count,
  output logic                  wb_err
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_busy;

  busy_table #(
    .NREGS (NREGS),
    .AW    (AW),
    .CW    (CW)
  ) u_busy_table (
    .clk        (clk),
    .reset_n    (reset_n),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .busy       (w_busy),
    .busy_count (busy_count),
    .wb_err     (wb_err)
  );

  // Entry 0 is never written; it stays at its reset value of zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (wb_valid && (wb_rd != '0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // Bypass is gated by reset_n so a writeback presented during reset cannot
  // leak onto the read ports.
  generate
    for (genvar k = 0; k < NREAD; k++) begin : g_rd_port
      logic [AW-1:0] w_addr;
      logic          w_hit;

      assign w_addr = rs_addr[k*AW +: AW];
      assign w_hit  = reset_n && wb_valid && (wb_rd == w_addr) && (w_addr != '0);

      assign rs_data[k*XLEN +: XLEN] = (!reset_n || (w_addr == '0)) ? '0      :
                                       w_hit                        ? wb_data :
                                                                      r_regs[w_addr];
      assign rs_busy[k] = w_hit ? 1'b0 : w_busy[w_addr];
    end
  endgenerate

endmodule : regfile_scoreboard
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_scoreboard
//  Purpose  : Directed self-checking bench for regfile_scoreboard, default
//             configuration plus an 8-register / 3-port / 16-bit instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_scoreboard;

  logic clk;
  logic reset_n;

  // Default instance: XLEN=32, NREGS=32, NREAD=2 (AW=5, CW=6)
  logic [9:0]  a_rs_addr;
  logic [63:0] a_rs_data;
  logic [1:0]  a_rs_busy;
  logic        a_iss_valid;
  logic [4:0]  a_iss_rd;
  logic        a_wb_valid;
  logic [4:0]  a_wb_rd;
  logic [31:0] a_wb_data;
  logic [5:0]  a_busy_count;
  logic        a_wb_err;

  // Swept instance: XLEN=16, NREGS=8, NREAD=3 (AW=3, CW=4)
  logic [8:0]  b_rs_addr;
  logic [47:0] b_rs_data;
  logic [2:0]  b_rs_busy;
  logic        b_iss_valid;
  logic [2:0]  b_iss_rd;
  logic        b_wb_valid;
  logic [2:0]  b_wb_rd;
  logic [15:0] b_wb_data;
  logic [3:0]  b_busy_count;
  logic        b_wb_err;

  int n_total;
  int n_bad;

  regfile_scoreboard u_dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .rs_addr    (a_rs_addr),
    .rs_data    (a_rs_data),
    .rs_busy    (a_rs_busy),
    .iss_valid  (a_iss_valid),
    .iss_rd     (a_iss_rd),
    .wb_valid   (a_wb_valid),
    .wb_rd      (a_wb_rd),
    .wb_data    (a_wb_data),
    .busy_count (a_busy_count),
    .wb_err     (a_wb_err)
  );

  regfile_scoreboard #(
    .XLEN  (16),
    .NREGS (8),
    .NREAD (3)
  ) u_dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .rs_addr    (b_rs_addr),
    .rs_data    (b_rs_data),
    .rs_busy    (b_rs_busy),
    .iss_valid  (b_iss_valid),
    .iss_rd     (b_iss_rd),
    .wb_valid   (b_wb_valid),
    .wb_rd      (b_wb_rd),
    .wb_data    (b_wb_data),
    .busy_count (b_busy_count),
    .wb_err     (b_wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_iss_valid = 1'b0;
    a_wb_valid  = 1'b0;
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    reset_n     = 1'b0;
    a_rs_addr   = '0;
    a_iss_valid = 1'b0;
    a_iss_rd    = '0;
    a_wb_valid  = 1'b0;
    a_wb_rd     = '0;
    a_wb_data   = '0;
    b_rs_addr   = '0;
    b_iss_valid = 1'b0;
    b_iss_rd    = '0;
    b_wb_valid  = 1'b0;
    b_wb_rd     = '0;
    b_wb_data   = '0;

    // Reset state
    #1;
    check("rst_count", 64'(a_busy_count), 64'd0);
    check("rst_err",   64'(a_wb_err),     64'd0);
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // Write x5 (unreserved -> wb_err), then async reset between edges
    a_wb_valid = 1'b1; a_wb_rd = 5'd5; a_wb_data = 32'hDEADBEEF;
    step();
    a_idle();
    a_rs_addr = {5'd0, 5'd5};
    #1;
    check("x5_written", 64'(a_rs_data[31:0]), 64'hDEADBEEF);
    check("x5_err",     64'(a_wb_err),        64'd1);
    reset_n = 1'b0;
    a_wb_valid = 1'b1; a_wb_rd = 5'd5; a_wb_data = 32'h11112222;
    #1;
    check("rst_x5_zero",   64'(a_rs_data[31:0]), 64'd0);
    check("rst_err_clr",   64'(a_wb_err),        64'd0);
    check("rst_cnt_clr",   64'(a_busy_count),    64'd0);
    a_idle();
    reset_n = 1'b1;
    step();
    check("x5_after_rst", 64'(a_rs_data[31:0]), 64'd0);

    // Issue x3, then writeback with same-cycle bypass
    a_iss_valid = 1'b1; a_iss_rd = 5'd3;
    step();
    a_idle();
    a_rs_addr = {5'd3, 5'd0};
    #1;
    check("x3_busy",  64'(a_rs_busy[1]),  64'd1);
    check("x3_count", 64'(a_busy_count),  64'd1);
    check("x0_port0", 64'(a_rs_data[31:0]), 64'd0);
    a_wb_valid = 1'b1; a_wb_rd = 5'd3; a_wb_data = 32'h1234;
    #1;
    check("x3_bypass_data", 64'(a_rs_data[63:32]), 64'h1234);
    check("x3_bypass_busy", 64'(a_rs_busy[1]),     64'd0);
    step();
    a_idle();
    #1;
    check("x3_count_after", 64'(a_busy_count),     64'd0);
    check("x3_stored",      64'(a_rs_data[63:32]), 64'h1234);
    check("x3_err",         64'(a_wb_err),         64'd0);

    // Reserve x7, then issue + writeback x7 on the same edge
    a_iss_valid = 1'b1; a_iss_rd = 5'd7;
    step();
    a_iss_valid = 1'b1; a_iss_rd = 5'd7;
    a_wb_valid  = 1'b1; a_wb_rd  = 5'd7; a_wb_data = 32'hA5A5A5A5;
    step();
    a_idle();
    a_rs_addr = {5'd0, 5'd7};
    #1;
    check("x7_data",  64'(a_rs_data[31:0]), 64'hA5A5A5A5);
    check("x7_busy",  64'(a_rs_busy[0]),    64'd1);
    check("x7_count", 64'(a_busy_count),    64'd1);
    check("x7_err",   64'(a_wb_err),        64'd0);
    // WAW: reissue an already-busy register, count must not move
    a_iss_valid = 1'b1; a_iss_rd = 5'd7;
    step();
    a_idle();
    check("x7_waw_count", 64'(a_busy_count), 64'd1);
    a_wb_valid = 1'b1; a_wb_rd = 5'd7; a_wb_data = 32'h0;
    step();
    a_idle();
    check("x7_released", 64'(a_busy_count), 64'd0);

    // x0: issue and writeback are ignored
    a_iss_valid = 1'b1; a_iss_rd = 5'd0;
    a_wb_valid  = 1'b1; a_wb_rd  = 5'd0; a_wb_data = 32'hFFFFFFFF;
    a_rs_addr   = {5'd0, 5'd0};
    #1;
    check("x0_no_bypass", 64'(a_rs_data[31:0]), 64'd0);
    step();
    a_idle();
    check("x0_data",  64'(a_rs_data[31:0]), 64'd0);
    check("x0_busy",  64'(a_rs_busy[0]),    64'd0);
    check("x0_count", 64'(a_busy_count),    64'd0);
    check("x0_err",   64'(a_wb_err),        64'd0);

    // Writeback to unreserved x9: data written, sticky error
    a_wb_valid = 1'b1; a_wb_rd = 5'd9; a_wb_data = 32'h55;
    step();
    a_idle();
    a_rs_addr = {5'd0, 5'd9};
    #1;
    check("x9_data", 64'(a_rs_data[31:0]), 64'h55);
    check("x9_err",  64'(a_wb_err),        64'd1);
    repeat (100) step();
    check("x9_err_sticky", 64'(a_wb_err), 64'd1);

    // Reservation made before a reset is discarded by it
    a_iss_valid = 1'b1; a_iss_rd = 5'd4;
    step();
    a_idle();
    check("x4_count", 64'(a_busy_count), 64'd1);
    reset_n = 1'b0;
    #1;
    check("x9_err_rst", 64'(a_wb_err),     64'd0);
    check("x4_cnt_rst", 64'(a_busy_count), 64'd0);
    reset_n = 1'b1;
    step();
    a_wb_valid = 1'b1; a_wb_rd = 5'd4; a_wb_data = 32'h4444;
    step();
    a_idle();
    check("x4_err_post_rst", 64'(a_wb_err), 64'd1);

    // Swept instance: reserve all seven nonzero registers
    for (int r = 1; r < 8; r++) begin
      b_iss_valid = 1'b1; b_iss_rd = 3'(r);
      step();
    end
    b_iss_valid = 1'b0;
    b_rs_addr = {3'd7, 3'd4, 3'd1};
    #1;
    check("b_count_full", 64'(b_busy_count), 64'd7);
    check("b_busy_all",   64'(b_rs_busy),    64'b111);
    b_wb_valid = 1'b1; b_wb_rd = 3'd4; b_wb_data = 16'hBEEF;
    #1;
    check("b_p1_bypass",  64'(b_rs_data[31:16]), 64'hBEEF);
    check("b_busy_byp",   64'(b_rs_busy),        64'b101);
    step();
    b_wb_valid = 1'b0;
    b_rs_addr = {3'd7, 3'd0, 3'd4};
    #1;
    check("b_count_6",  64'(b_busy_count),     64'd6);
    check("b_p0_data",  64'(b_rs_data[15:0]),  64'hBEEF);
    check("b_p1_x0",    64'(b_rs_data[31:16]), 64'd0);
    check("b_p2_data",  64'(b_rs_data[47:32]), 64'd0);
    check("b_busy_mix", 64'(b_rs_busy),        64'b100);
    check("b_err",      64'(b_wb_err),         64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_regfile_scoreboard
`default_nettype wire
